// File: rtl/serial_clock_receiver_if.sv
// Serial receive link bundle: the serial line pair in, the recovered word and status out.
// The receiver connects through the slave modport; the line driver or the bench uses master.
interface serial_clock_receiver_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  serial_clk;
  logic                  serial_data;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  busy;
  logic                  frame_error;

  modport master (
    output serial_clk,
    output serial_data,
    input  data_out,
    input  data_valid,
    input  busy,
    input  frame_error
  );

  modport slave (
    input  serial_clk,
    input  serial_data,
    output data_out,
    output data_valid,
    output busy,
    output frame_error
  );
endinterface

// File: rtl/serial_clock_receiver.sv
// Receiver for the divided serial clock/data link.
// serial_clk and serial_data arrive asynchronous to clk. Both lines pass through
// synchronizers of equal depth. Rising edges of serial_clk shift data in MSB-first.
// A completed word produces a one-cycle data_valid. A frame that stalls produces a
// one-cycle frame_error instead.
// Optional feature macro: SERIAL_RX_PARITY_EN. When it is defined, each frame carries one
// extra even-parity bit after the data, and a parity failure raises frame_error.
module serial_clock_receiver #(
  parameter int DATA_WIDTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_clock_receiver_if.slave bus
);

`ifdef SERIAL_RX_PARITY_EN
  localparam int FRAME_BITS = DATA_WIDTH + 1;
`else
  localparam int FRAME_BITS = DATA_WIDTH;
`endif
  // The shift register holds every frame bit except the one arriving on the final edge.
  localparam int SH_W  = FRAME_BITS - 1;
  localparam int BC_W  = $clog2(FRAME_BITS + 1);
  localparam int IC_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SUP_W = $clog2(SYNC_STAGES + 2);

  typedef enum logic {IDLE, RECEIVE} state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   sync_clk;
  logic                   sync_clk_d;
  logic                   sync_data;
  logic [SUP_W-1:0]       sup_cnt;
  logic                   edge_en;
  logic                   rise;

  state_t                 state, state_nx;
  logic [BC_W-1:0]        bit_count, bit_count_nx;
  logic [IC_W-1:0]        idle_count, idle_count_nx;
  logic [SH_W-1:0]        shreg, shreg_nx;
  logic [DATA_WIDTH-1:0]  word;
  logic                   word_done;
  logic                   word_err;

  logic [DATA_WIDTH-1:0]  data_out_r;
  logic                   data_valid_r;
  logic                   frame_error_r;

  // Synchronizer chains: serial_clk and serial_data keep equal latency, so the data bit
  // is aligned with the clock edge it was launched for.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync   <= '0;
      data_sync  <= '0;
      sync_clk_d <= 1'b0;
    end else begin
      clk_sync   <= {clk_sync[SYNC_STAGES-2:0], bus.serial_clk};
      data_sync  <= {data_sync[SYNC_STAGES-2:0], bus.serial_data};
      sync_clk_d <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign sync_clk  = clk_sync[SYNC_STAGES-1];
  assign sync_data = data_sync[SYNC_STAGES-1];

  // Edge detection stays blocked while the cleared chains fill after reset. During this
  // time a line that was already high looks like a rise, so it must be ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      sup_cnt <= '0;
    end else if (!edge_en) begin
      sup_cnt <= sup_cnt + 1'b1;
    end
  end

  assign edge_en = (sup_cnt == SUP_W'(SYNC_STAGES + 1));
  assign rise    = edge_en & sync_clk & ~sync_clk_d;

  // FSM state and frame counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_count  <= '0;
      idle_count <= '0;
    end else begin
      state      <= state_nx;
      bit_count  <= bit_count_nx;
      idle_count <= idle_count_nx;
    end
  end

  // The shift register is datapath only. A fresh frame always overwrites it fully.
  always_ff @(posedge clk) begin
    shreg <= shreg_nx;
  end

  // Next-state logic. A rise always beats the timeout terminal count.
  always_comb begin
    state_nx      = state;
    bit_count_nx  = bit_count;
    idle_count_nx = idle_count;
    shreg_nx      = shreg;
    word_done     = 1'b0;
    word_err      = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    word          = shreg;
`else
    word          = {shreg, sync_data};
`endif
    case (state)
      IDLE: begin
        if (rise) begin
          shreg_nx      = SH_W'({shreg, sync_data});
          bit_count_nx  = BC_W'(1);
          idle_count_nx = '0;
          state_nx      = RECEIVE;
        end
      end
      RECEIVE: begin
        if (rise) begin
          shreg_nx      = SH_W'({shreg, sync_data});
          idle_count_nx = '0;
          if (bit_count == BC_W'(FRAME_BITS - 1)) begin
            state_nx     = IDLE;
            bit_count_nx = '0;
`ifdef SERIAL_RX_PARITY_EN
            if (^{shreg, sync_data} == 1'b0) begin
              word_done = 1'b1;
            end else begin
              word_err  = 1'b1;
            end
`else
            word_done = 1'b1;
`endif
          end else begin
            bit_count_nx = bit_count + 1'b1;
          end
        end else if (idle_count == IC_W'(TIMEOUT_CYCLES - 1)) begin
          word_err      = 1'b1;
          state_nx      = IDLE;
          bit_count_nx  = '0;
          idle_count_nx = '0;
        end else begin
          idle_count_nx = idle_count + 1'b1;
        end
      end
      default: begin
        state_nx     = IDLE;
        bit_count_nx = '0;
      end
    endcase
  end

  // Output register: results appear one cycle after the deciding edge. data_out holds
  // until the next good word arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_r    <= '0;
      data_valid_r  <= 1'b0;
      frame_error_r <= 1'b0;
    end else begin
      data_valid_r  <= word_done;
      frame_error_r <= word_err;
      if (word_done) begin
        data_out_r <= word;
      end
    end
  end

  assign bus.data_out    = data_out_r;
  assign bus.data_valid  = data_valid_r;
  assign bus.frame_error = frame_error_r;
  assign bus.busy        = (state == RECEIVE);

endmodule
